// File: rtl/adder32_seq.sv
// adder32_seq: byte-serial W-bit adder/subtractor (W = 8*SLICES).
// One 8-bit carry-lookahead slice (all_gates_a) is reused once per cycle,
// LSB byte first, under a three-state IDLE/BUSY/DONE handshake FSM.
// Optional feature macro: ADDER32_SEQ_SUB_EN. When defined, 'sub' selects A-B.
// When undefined, 'sub' is ignored and the block only adds.

// 8-bit carry-lookahead slice: sum only, no carry-out port.
module all_gates_a (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s
);
   logic [7:0] g_s;
   logic [7:0] p_s;
   logic [7:0] c_s;
   logic       prod_s;
   logic       acc_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Each carry is flattened into generate/propagate sum-of-products terms
   always_comb begin
      c_s    = 8'h00;
      prod_s = 1'b1;
      acc_s  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         prod_s = 1'b1;
         acc_s  = 1'b0;
         for (int j = i - 1; j >= 0; j--) begin
            acc_s  = acc_s | (prod_s & g_s[j]);
            prod_s = prod_s & p_s[j];
         end
         c_s[i] = acc_s | (prod_s & cin);
      end
   end

   assign s = p_s ^ c_s;
endmodule

module adder32_seq #(
   parameter int SLICES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*SLICES-1:0]   op_a,
   input  logic [8*SLICES-1:0]   op_b,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*SLICES-1:0]   sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  zero
);
   localparam int W = 8 * SLICES;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           carry_q, carry_d;
   logic [2:0]     idx_q, idx_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;
   logic           zero_q, zero_d;

   logic           sub_eff_s;
   logic [7:0]     a_byte_s;
   logic [7:0]     b_byte_s;
   logic [7:0]     s_byte_s;
   logic           c7_s;
   logic           byte_cout_s;
   logic           last_s;

`ifdef ADDER32_SEQ_SUB_EN
   assign sub_eff_s = sub;
`else
   // Add-only build: the port stays but carries no meaning
   assign sub_eff_s = sub & 1'b0;
`endif

   // Select the operand byte addressed by the current byte index
   always_comb begin
      a_byte_s = 8'h00;
      b_byte_s = 8'h00;
      for (int i = 0; i < SLICES; i++) begin
         a_byte_s = a_byte_s | ((idx_q == 3'(i)) ? a_q[8*i +: 8] : 8'h00);
         b_byte_s = b_byte_s | ((idx_q == 3'(i)) ? b_q[8*i +: 8] : 8'h00);
      end
   end

   all_gates_a u_slice (
      .a   (a_byte_s),
      .b   (b_byte_s),
      .cin (carry_q),
      .s   (s_byte_s)
   );

   // The slice hides its carry-out, so rebuild it from bit 7 of the result
   assign c7_s        = s_byte_s[7] ^ a_byte_s[7] ^ b_byte_s[7];
   assign byte_cout_s = (a_byte_s[7] & b_byte_s[7]) | ((a_byte_s[7] ^ b_byte_s[7]) & c7_s);
   assign last_s      = (idx_q == 3'(SLICES - 1));

   // Next-state and datapath update for the IDLE/BUSY/DONE sequencer
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = sub_eff_s ? ~op_b : op_b;
               carry_d = sub_eff_s;
               idx_d   = 3'd0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            for (int i = 0; i < SLICES; i++) begin
               sum_d[8*i +: 8] = (idx_q == 3'(i)) ? s_byte_s : sum_q[8*i +: 8];
            end
            carry_d = byte_cout_s;
            idx_d   = idx_q + 3'd1;
            if (last_s) begin
               cout_d  = byte_cout_s;
               ovf_d   = c7_s ^ byte_cout_s;
               zero_d  = (sum_d == {W{1'b0}});
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         sum_q   <= {W{1'b0}};
         carry_q <= 1'b0;
         idx_q   <= 3'd0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_adder32_seq.sv
// tb_adder32_seq: scoreboard bench for adder32_seq (SLICES = 4).
// Driver pushes the reference result on every accept; an independent monitor
// pops and compares on each out_valid/out_ready handshake.
module tb_adder32_seq;
   localparam int SLICES = 4;
   localparam int W      = 8 * SLICES;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [W-1:0]  op_a      = '0;
   logic [W-1:0]  op_b      = '0;
   logic          sub       = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic          zero;

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
      logic         o;
      logic         z;
      int           acc;
   } exp_t;

   exp_t          sb[$];
   int            n_pass  = 0;
   int            n_total = 0;
   int            cyc     = 0;
   int            rdy_mode = 1;
   bit            prev_v  = 1'b0;
   logic [W+2:0]  held;

   adder32_seq #(.SLICES(SLICES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer backpressure: 0 = stall, 1 = always ready, other = random
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain (W+1)-bit arithmetic on the effective operands
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input int acc);
      exp_t         e;
      logic [W:0]   t;
      logic [W-1:0] bb;
      logic         se;
`ifdef ADDER32_SEQ_SUB_EN
      se = s;
`else
      se = 1'b0;
`endif
      bb    = se ? ~b : b;
      t     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, se};
      e.sum = t[W-1:0];
      e.c   = t[W];
      e.o   = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      e.z   = (t[W-1:0] == {W{1'b0}});
      e.acc = acc;
      return e;
   endfunction

   // Monitor: latency on first valid, stability while stalled, compare on handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v <= 1'b0;
      end else begin
         if (out_valid) begin
            if (!prev_v) begin
               if (sb.size() == 0) begin
                  chk("spurious_out_valid", out_valid, 1'b0);
               end else begin
                  chk("latency", 64'(cyc - sb[0].acc), 64'(SLICES));
               end
               held <= {sum, cout, ovf, zero};
            end else begin
               chk("hold_stable", {sum, cout, ovf, zero}, held);
               chk("hold_in_ready", in_ready, 1'b0);
            end
            if (out_ready && sb.size() != 0) begin
               chk("result", {sum, cout, ovf, zero}, {sb[0].sum, sb[0].c, sb[0].o, sb[0].z});
               void'(sb.pop_front());
            end
         end
         prev_v <= out_valid && !out_ready;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input bit push);
      int guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 100) begin
         in_valid = 1'($urandom);
         op_a     = $urandom;
         op_b     = $urandom;
         sub      = 1'($urandom);
         guard++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1'b1);
         in_valid = 1'b0;
      end else begin
         in_valid = 1'b1;
         op_a     = a;
         op_b     = b;
         sub      = s;
         if (push) sb.push_back(model(a, b, s, cyc + 1));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         op_a     = $urandom;
         op_b     = $urandom;
         sub      = 1'($urandom);
      end
   endtask

   task automatic drain();
      int guard = 0;
      @(negedge clk);
      while ((sb.size() != 0 || out_valid) && guard < 300) begin
         guard++;
         @(negedge clk);
      end
      if (sb.size() != 0 || out_valid) chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           g;
      rdy_mode = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", {in_ready, out_valid, sum, cout, ovf, zero}, {1'b1, 1'b0, {W{1'b0}}, 3'b000});

      // Directed boundary cases
      issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1); drain();
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1); drain();
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1); drain();
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1); drain();
      issue(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1); drain();
      issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1); drain();

      // Stall in DONE for 5 cycles while poking inputs
      rdy_mode = 0;
      issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
      g = 0;
      while (!out_valid && g < 20) begin g++; @(negedge clk); end
      chk("stall_reached_done", out_valid, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         op_a     = $urandom;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rdy_mode = 1;
      drain();
      repeat (4) begin
         @(negedge clk);
         chk("no_accept_after_stall", {out_valid, in_ready}, 2'b01);
      end

      // Reset during the second BUSY cycle
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_idle", {in_ready, out_valid, sum}, {1'b1, 1'b0, {W{1'b0}}});
      rst_n = 1'b1;
      for (int k = 0; k < SLICES + 3; k++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 1'b0);
      end

      // Randomized traffic with random backpressure
      rdy_mode = 2;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = ~a;
            1:       b = -a;
            2:       b = 32'h8000_0000 - a;
            default: b = $urandom;
         endcase
         issue(a, b, 1'($urandom), 1'b1);
      end
      drain();
      rdy_mode = 1;
      repeat (3) @(negedge clk);
      chk("final_queue_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/adder32_seq.md
ADDER32_SEQ -- requirements
Module: adder32_seq

Interface
REQ-001 SHALL have parameter SLICES, default 4, meaning the number of 8-bit slices; operand width W = 8*SLICES; legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port op_a  input  W  operand A.
REQ-007 SHALL have port op_b  input  W  operand B.
REQ-008 SHALL have port sub  input  1  1 = A-B, 0 = A+B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  W  result.
REQ-012 SHALL have port cout  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow.
REQ-014 SHALL have port zero  output  1  sum == 0.

Function
REQ-015 SHALL instantiate one all_gates_a 8-bit carry-lookahead slice and reuse it once per cycle, byte-serially, LSB byte first.
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->BUSY on in_valid&in_ready; BUSY->DONE after the byte with index SLICES-1; DONE->IDLE on out_ready.
REQ-017 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE; no overlap of accepted requests.
REQ-018 SHALL, on accept, latch op_a, op_b (bitwise inverted when sub=1), carry register = sub, byte index = 0; later input changes are ignored until the next accept.
REQ-019 SHALL, per BUSY cycle, write the slice output to sum[8*idx+7:8*idx], update the carry register with that byte's carry-out, and increment idx.
REQ-020 SHALL derive byte carry-out as (a7&b7)|((a7^b7)&c7), with c7 = s7^a7^b7, since the slice exposes no carry-out.
REQ-021 SHALL assert out_valid exactly SLICES clock edges after the accepting edge (latency SLICES+1 cycles, including the DONE cycle).
REQ-022 SHALL set cout = carry out of bit W-1, ovf = carry into bit W-1 XOR cout, zero = (sum == 0), all valid when out_valid=1.
REQ-023 SHALL hold sum, cout, ovf, zero stable from DONE entry until the next accept; out_valid held while out_ready=0.
REQ-024 SHALL wrap modulo 2^W: all-ones + 1 gives sum=0, cout=1, zero=1.
REQ-025 SHALL ignore in_valid in BUSY/DONE, and ignore out_ready outside DONE.

Reset
REQ-026 SHALL, with rst_n=0 at a rising edge, enter IDLE and clear sum, cout, ovf, zero, idx, carry register, and out_valid to 0, with in_ready=1 from the first cycle after release.
REQ-027 SHALL abandon any in-flight operation on reset mid-BUSY or mid-DONE, without producing out_valid for it.

Configuration
REQ-028 SHALL support macro ADDER32_SEQ_SUB_EN: when it is defined, sub selects subtraction per REQ-018; when it is undefined, the sub port remains present, is ignored, and is treated as 0 (add only).

Verification
REQ-029 SHALL cover the following: add 0x0000_0001 + 0x0000_0002, sub=0 -> sum=0x0000_0003, cout=0, ovf=0, zero=0, out_valid 4 edges after accept.
REQ-030 SHALL cover the following: add 0xFFFF_FFFF + 0x0000_0001 -> sum=0, cout=1, zero=1, ovf=0 (carry ripples through all 4 slices).
REQ-031 SHALL cover the following: add 0x7FFF_FFFF + 0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0; with SUB_EN, sub 0x0000_0005 - 0x0000_0007 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
REQ-032 SHALL cover the following: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/op_a -> out_valid and sum stay stable, in_ready=0, and no new accept occurs.
REQ-033 SHALL cover the following: rst_n=0 during the 2nd BUSY cycle -> next cycle IDLE, in_ready=1, sum=0, and no out_valid for the aborted request.
REQ-034 SHALL cover the following: without ADDER32_SEQ_SUB_EN, sub=1 with 0x10 and 0x01 -> sum=0x0000_0011.
